// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//   Holds the game's sheet-music table and plays a selected melody in real
//   time. Requests are arbitrated by priority. Playback can loop or be stopped.
//   Every note ends with a silent articulation gap.
//
// Ports
//   clk          in   system clock (only clock)
//   reset        in   synchronous, active-high reset
//   startReq     in   single-cycle request to play melodySelect
//   melodySelect in   [3:0] melody ID, sampled with startReq
//   loopEn       in   level; sampled at melody end, 1 restarts the melody
//   stopReq      in   single-cycle abort request (wins over startReq)
//   tone         out  [3:0] note index to the tone decoder, 4'hF = silence
//   silenceOutN  out  0 while tone is 4'hF, else 1
//   busy         out  high while a melody is active
//   melodyDone   out  one-cycle pulse on natural (non-looped) completion
//   curMelody    out  [3:0] active melody ID, 0 when idle
//
// The FSM stage holds the playback state. The output stage registers a view
// of that state one cycle later. A request sampled at edge k therefore shows
// on the outputs at edge k+1.
// -----------------------------------------------------------------------------
module melody_sequencer #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_250_000,
   parameter int MAX_NOTES   = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startReq,
   input  logic [3:0] melodySelect,
   input  logic       loopEn,
   input  logic       stopReq,
   output logic [3:0] tone,
   output logic       silenceOutN,
   output logic       busy,
   output logic       melodyDone,
   output logic [3:0] curMelody
);

   localparam int IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
   // Holds up to 15*BEAT_CYCLES-1; 15*BEAT_CYCLES is never a power of two.
   localparam int CNT_W = $clog2(15 * BEAT_CYCLES);
   localparam logic [CNT_W-1:0] BEAT_C = CNT_W'(BEAT_CYCLES);
   localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYCLES);
   localparam logic [IDX_W:0]   MAX_C  = (IDX_W + 1)'(MAX_NOTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Sheet-music table: returns {note, length}. Length 0 terminates a melody.
   function automatic logic [7:0] note_entry(input logic [3:0] id, input logic [IDX_W-1:0] idx);
      logic [7:0]  e;
      logic [31:0] i;
      e = {4'hF, 4'd0};
      i = 32'(idx);
      case (id)
         4'd1: case (i)
            32'd0:   e = {4'h0, 4'd1};
            32'd1:   e = {4'h4, 4'd1};
            32'd2:   e = {4'h7, 4'd1};
            32'd3:   e = {4'hC, 4'd4};
            default: e = {4'hF, 4'd0};
         endcase
         4'd2: case (i)
            32'd0:   e = {4'h7, 4'd2};
            32'd1:   e = {4'h5, 4'd2};
            32'd2:   e = {4'h4, 4'd2};
            32'd3:   e = {4'h0, 4'd6};
            default: e = {4'hF, 4'd0};
         endcase
         4'd3: case (i)
            32'd0:   e = {4'h2, 4'd1};
            32'd1:   e = {4'h3, 4'd1};
            32'd2:   e = {4'h2, 4'd1};
            32'd3:   e = {4'h3, 4'd1};
            default: e = {4'hF, 4'd0};
         endcase
         4'd4: case (i)
            32'd0:   e = {4'hB, 4'd1};
            32'd1:   e = {4'hC, 4'd4};
            default: e = {4'hF, 4'd0};
         endcase
         4'd5: case (i)
            32'd0:   e = {4'h0, 4'd1};
            32'd1:   e = {4'h1, 4'd4};
            default: e = {4'hF, 4'd0};
         endcase
         default: e = {4'hF, 4'd0};
      endcase
      return e;
   endfunction

   // Request priority. 0 marks an invalid ID.
   function automatic logic [1:0] prio_of(input logic [3:0] id);
      logic [1:0] p;
      case (id)
         4'd1, 4'd2: p = 2'd3;
         4'd4, 4'd5: p = 2'd2;
         4'd3:       p = 2'd1;
         default:    p = 2'd0;
      endcase
      return p;
   endfunction

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       mel_q, mel_d;
   logic [1:0]       prio_q, prio_d;
   logic             done_pend_q, done_pend_d;
   logic [3:0]       tone_q, tone_d;
   logic             sil_n_q, sil_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [3:0]       cur_q, cur_d;

   logic [7:0]       cur_entry;
   logic [7:0]       next_entry;
   logic [CNT_W-1:0] note_cycles;
   logic [IDX_W:0]   idx_next;
   logic [1:0]       new_prio;
   logic             start_ok;
   logic             note_end;
   logic             melody_end;

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         mel_q       <= 4'd0;
         prio_q      <= 2'd0;
         done_pend_q <= 1'b0;
         tone_q      <= 4'hF;
         sil_n_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cur_q       <= 4'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         mel_q       <= mel_d;
         prio_q      <= prio_d;
         done_pend_q <= done_pend_d;
         tone_q      <= tone_d;
         sil_n_q     <= sil_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cur_q       <= cur_d;
      end
   end

   // Playback FSM: note timing, index stepping, loop/end, preemption and stop.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      mel_d       = mel_q;
      prio_d      = prio_q;
      done_pend_d = 1'b0;
      note_end    = 1'b0;

      cur_entry   = note_entry(mel_q, idx_q);
      note_cycles = CNT_W'(cur_entry[3:0]) * BEAT_C;
      idx_next    = {1'b0, idx_q} + (IDX_W + 1)'(1);
      next_entry  = note_entry(mel_q, idx_next[IDX_W-1:0]);
      melody_end  = (idx_next >= MAX_C) || (next_entry[3:0] == 4'd0);
      new_prio    = prio_of(melodySelect);
      start_ok    = startReq && (new_prio != 2'd0) &&
                    ((state_q == IDLE) || (new_prio >= prio_q));

      case (state_q)
         IDLE: begin
            cnt_d = '0;
         end
         PLAY: begin
            // The play part ends GAP_CYCLES before the full note length.
            if (cnt_q == note_cycles - GAP_C - CNT_W'(1)) begin
               if (GAP_CYCLES == 0) begin
                  note_end = 1'b1;
               end else begin
                  state_d = GAP;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == note_cycles - CNT_W'(1)) begin
               note_end = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (note_end) begin
         cnt_d = '0;
         if (melody_end) begin
            idx_d = '0;
            if (loopEn) begin
               state_d = PLAY;
            end else begin
               state_d     = IDLE;
               mel_d       = 4'd0;
               prio_d      = 2'd0;
               done_pend_d = 1'b1;
            end
         end else begin
            idx_d   = idx_next[IDX_W-1:0];
            state_d = PLAY;
         end
      end else begin
         idx_d = idx_q;
      end

      // A stop beats everything. An accepted start beats a natural end and
      // suppresses its done pulse.
      if (stopReq) begin
         state_d     = IDLE;
         idx_d       = '0;
         cnt_d       = '0;
         mel_d       = 4'd0;
         prio_d      = 2'd0;
         done_pend_d = 1'b0;
      end else if (start_ok) begin
         state_d     = PLAY;
         idx_d       = '0;
         cnt_d       = '0;
         mel_d       = melodySelect;
         prio_d      = new_prio;
         done_pend_d = 1'b0;
      end else begin
         mel_d = mel_d;
      end
   end

   // Output stage: registered view of the current FSM state.
   always_comb begin
      tone_d  = (state_q == PLAY) ? cur_entry[7:4] : 4'hF;
      sil_n_d = (tone_d != 4'hF);
      busy_d  = (state_q != IDLE);
      cur_d   = busy_d ? mel_q : 4'd0;
      done_d  = done_pend_q;
   end

   assign tone        = tone_q;
   assign silenceOutN = sil_n_q;
   assign busy        = busy_q;
   assign melodyDone  = done_q;
   assign curMelody   = cur_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//   Scoreboard bench for melody_sequencer with BEAT_CYCLES=4 and GAP_CYCLES=1.
//   Each scenario pushes hand-derived expected outputs, tagged with an
//   absolute output cycle, into a queue and then drives its stimulus. A
//   separate monitor compares the DUT outputs against the queue head on every
//   falling edge.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       startReq = 1'b0;
   logic [3:0] melodySelect = 4'd0;
   logic       loopEn = 1'b0;
   logic       stopReq = 1'b0;
   logic [3:0] tone;
   logic       silenceOutN;
   logic       busy;
   logic       melodyDone;
   logic [3:0] curMelody;

   typedef struct {
      int         cyc;
      logic [3:0] tone;
      logic       busy;
      logic       done;
      logic [3:0] cur;
      string      tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   edge_n = 0;
   int   base   = 0;
   int   tests  = 0;
   int   fails  = 0;

   melody_sequencer #(
      .BEAT_CYCLES(4),
      .GAP_CYCLES (1),
      .MAX_NOTES  (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .startReq    (startReq),
      .melodySelect(melodySelect),
      .loopEn      (loopEn),
      .stopReq     (stopReq),
      .tone        (tone),
      .silenceOutN (silenceOutN),
      .busy        (busy),
      .melodyDone  (melodyDone),
      .curMelody   (curMelody)
   );

   always #5 clk = ~clk;

   // Output cycle n is the value registered at rising edge n.
   always @(posedge clk) edge_n <= edge_n + 1;

   // Monitor: compares every queued expectation that is due this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
         mon_e = sb.pop_front();
         tests = tests + 1;
         if (mon_e.cyc != edge_n || tone !== mon_e.tone ||
             silenceOutN !== (mon_e.tone != 4'hF) || busy !== mon_e.busy ||
             melodyDone !== mon_e.done || curMelody !== mon_e.cur) begin
            fails = fails + 1;
            $display("FAIL %s @cycle %0d (rel %0d): got tone=%h silN=%b busy=%b done=%b cur=%h, required tone=%h silN=%b busy=%b done=%b cur=%h",
                     mon_e.tag, edge_n, mon_e.cyc - base, tone, silenceOutN, busy, melodyDone,
                     curMelody, mon_e.tone, (mon_e.tone != 4'hF), mon_e.busy, mon_e.done, mon_e.cur);
         end
      end
   end

   task automatic go_to(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   task automatic exp_rng(input int c0, input int c1, input logic [3:0] t, input logic bz,
                          input logic dn, input logic [3:0] cur, input string tag);
      exp_t e;
      for (int c = c0; c <= c1; c++) begin
         e.cyc  = base + c;
         e.tone = t;
         e.busy = bz;
         e.done = dn;
         e.cur  = cur;
         e.tag  = tag;
         sb.push_back(e);
      end
   endtask

   // Present inputs so that they are sampled at edge base+e, for one cycle.
   task automatic drive(input int e, input logic st, input logic [3:0] id,
                        input logic sp, input logic rs);
      go_to(base + e - 1);
      startReq     = st;
      melodySelect = id;
      stopReq      = sp;
      reset        = rs;
      go_to(base + e);
      startReq = 1'b0;
      stopReq  = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic drain(input int last);
      int budget;
      budget = 0;
      go_to(base + last);
      while (sb.size() > 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      tests = tests + 1;
      if (sb.size() > 0) begin
         fails = fails + 1;
         $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic new_scn();
      base = edge_n + 1;
   endtask

   // Win melody, request at relative edge 0, natural end at cycle 29.
   task automatic run_win(input string tag);
      new_scn();
      exp_rng(1, 3, 4'h0, 1'b1, 1'b0, 4'd1, tag);
      exp_rng(4, 4, 4'hF, 1'b1, 1'b0, 4'd1, tag);
      exp_rng(5, 7, 4'h4, 1'b1, 1'b0, 4'd1, tag);
      exp_rng(8, 8, 4'hF, 1'b1, 1'b0, 4'd1, tag);
      exp_rng(9, 11, 4'h7, 1'b1, 1'b0, 4'd1, tag);
      exp_rng(12, 12, 4'hF, 1'b1, 1'b0, 4'd1, tag);
      exp_rng(13, 27, 4'hC, 1'b1, 1'b0, 4'd1, tag);
      exp_rng(28, 28, 4'hF, 1'b1, 1'b0, 4'd1, {tag, "_last_gap"});
      exp_rng(29, 29, 4'hF, 1'b0, 1'b1, 4'd0, {tag, "_done"});
      exp_rng(30, 31, 4'hF, 1'b0, 1'b0, 4'd0, {tag, "_idle"});
      drive(0, 1'b1, 4'd1, 1'b0, 1'b0);
      drain(31);
   endtask

   initial begin
      // Reset state.
      base = 0;
      exp_rng(1, 4, 4'hF, 1'b0, 1'b0, 4'd0, "reset_state");
      go_to(2);
      reset = 1'b0;
      drain(4);

      run_win("win");

      // Looped claw: four passes of period 16, then loopEn drops mid pass 4.
      loopEn = 1'b1;
      new_scn();
      for (int p = 0; p < 4; p++) begin
         exp_rng(16 * p + 1, 16 * p + 3, 4'h2, 1'b1, 1'b0, 4'd3, "claw_loop");
         exp_rng(16 * p + 4, 16 * p + 4, 4'hF, 1'b1, 1'b0, 4'd3, "claw_loop");
         exp_rng(16 * p + 5, 16 * p + 7, 4'h3, 1'b1, 1'b0, 4'd3, "claw_loop");
         exp_rng(16 * p + 8, 16 * p + 8, 4'hF, 1'b1, 1'b0, 4'd3, "claw_loop");
         exp_rng(16 * p + 9, 16 * p + 11, 4'h2, 1'b1, 1'b0, 4'd3, "claw_loop");
         exp_rng(16 * p + 12, 16 * p + 12, 4'hF, 1'b1, 1'b0, 4'd3, "claw_loop");
         exp_rng(16 * p + 13, 16 * p + 15, 4'h3, 1'b1, 1'b0, 4'd3, "claw_loop");
         exp_rng(16 * p + 16, 16 * p + 16, 4'hF, 1'b1, 1'b0, 4'd3, "claw_loop");
      end
      exp_rng(65, 65, 4'hF, 1'b0, 1'b1, 4'd0, "claw_done");
      exp_rng(66, 67, 4'hF, 1'b0, 1'b0, 4'd0, "claw_idle");
      drive(0, 1'b1, 4'd3, 1'b0, 1'b0);
      go_to(base + 52);
      loopEn = 1'b0;
      drain(67);

      // Preemption: claw -> gold (higher), claw ignored (lower), stone (equal).
      new_scn();
      exp_rng(1, 3, 4'h2, 1'b1, 1'b0, 4'd3, "pre_claw");
      exp_rng(4, 4, 4'hF, 1'b1, 1'b0, 4'd3, "pre_claw");
      exp_rng(5, 6, 4'h3, 1'b1, 1'b0, 4'd3, "pre_claw");
      exp_rng(7, 9, 4'hB, 1'b1, 1'b0, 4'd4, "pre_gold");
      exp_rng(10, 10, 4'hF, 1'b1, 1'b0, 4'd4, "pre_gold");
      exp_rng(11, 16, 4'hC, 1'b1, 1'b0, 4'd4, "low_prio_ignored");
      exp_rng(17, 19, 4'h0, 1'b1, 1'b0, 4'd5, "equal_prio");
      exp_rng(20, 20, 4'hF, 1'b1, 1'b0, 4'd5, "equal_prio");
      exp_rng(21, 35, 4'h1, 1'b1, 1'b0, 4'd5, "stone");
      exp_rng(36, 36, 4'hF, 1'b1, 1'b0, 4'd5, "stone");
      exp_rng(37, 37, 4'hF, 1'b0, 1'b1, 4'd0, "stone_done");
      exp_rng(38, 38, 4'hF, 1'b0, 1'b0, 4'd0, "stone_idle");
      drive(0, 1'b1, 4'd3, 1'b0, 1'b0);
      drive(6, 1'b1, 4'd4, 1'b0, 1'b0);
      drive(12, 1'b1, 4'd3, 1'b0, 1'b0);
      drive(16, 1'b1, 4'd5, 1'b0, 1'b0);
      drain(38);

      // Stop together with start mid-melody: stop wins, no done pulse.
      new_scn();
      exp_rng(1, 5, 4'h7, 1'b1, 1'b0, 4'd2, "loss_play");
      exp_rng(6, 12, 4'hF, 1'b0, 1'b0, 4'd0, "stop_wins");
      drive(0, 1'b1, 4'd2, 1'b0, 1'b0);
      drive(5, 1'b1, 4'd1, 1'b1, 1'b0);
      drain(12);

      // Invalid IDs while idle are ignored.
      new_scn();
      exp_rng(1, 8, 4'hF, 1'b0, 1'b0, 4'd0, "invalid_id");
      drive(0, 1'b1, 4'd0, 1'b0, 1'b0);
      drive(3, 1'b1, 4'd9, 1'b0, 1'b0);
      drain(8);

      // Reset in the middle of a loss note, then a fresh win.
      new_scn();
      exp_rng(1, 3, 4'h7, 1'b1, 1'b0, 4'd2, "loss_pre_reset");
      exp_rng(4, 6, 4'hF, 1'b0, 1'b0, 4'd0, "reset_mid");
      drive(0, 1'b1, 4'd2, 1'b0, 1'b0);
      drive(4, 1'b0, 4'd0, 1'b0, 1'b1);
      drain(6);

      run_win("win_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 time units, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Parametrised sound sequencer for the game audio path. It holds the game's sheet-music table and steps through a selected melody in real time, so game logic no longer has to drive a note index. It arbitrates competing sound requests by priority, supports looped playback and forced stop, and inserts an articulation gap between notes. The block sits between the game-event logic and the tone decoder / sound generator.

## Interface
- `BEAT_CYCLES`, default 12_500_000: clock cycles per beat (0.25 s at 50 MHz). Must be ≥ 2.
- `GAP_CYCLES`, default 1_250_000: silent cycles at the end of every note. Legal range is 0 ≤ GAP_CYCLES < BEAT_CYCLES.
- `MAX_NOTES`, default 32: table depth per melody. The note index width is clog2(MAX_NOTES).
- `clk`, input, 1: system clock. This is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `startReq`, input, 1: single-cycle request to play `melodySelect`.
- `melodySelect`, input, 4: melody ID sampled when `startReq`=1.
- `loopEn`, input, 1: level input, sampled at end of melody. When 1, the current melody restarts.
- `stopReq`, input, 1: single-cycle request to abort playback.
- `tone`, output, 4: note index to the tone decoder. 4'hF means silence.
- `silenceOutN`, output, 1: 0 when `tone`=4'hF, else 1.
- `busy`, output, 1: high while a melody is active.
- `melodyDone`, output, 1: one-cycle pulse on natural (non-looped) completion.
- `curMelody`, output, 4: ID of the active melody. It is 0 when idle.

## Operation
- **Note encoding.** Notes are 0=do, 1=do#, 2=re, 3=re#, 4=mi, 5=fa, 6=fa#, 7=sol, 8=sol#, 9=la, A=la#, B=si, C=do', D=do#', E=re', F=silence.
- **Melody table.** Each entry is (note, length in beats, 1..15). A length of 0 terminates the melody.
  - ID 1, Win: (0,1)(4,1)(7,1)(C,4).
  - ID 2, Loss: (7,2)(5,2)(4,2)(0,6).
  - ID 3, Claw: (2,1)(3,1)(2,1)(3,1).
  - ID 4, Gold: (B,1)(C,4).
  - ID 5, Stone: (0,1)(1,4).
  - IDs 0 and 6–15 are invalid. A request with an invalid ID is ignored.
- **Priority.** IDs 1 and 2 have priority 3, IDs 4 and 5 have priority 2, and ID 3 has priority 1.
- **FSM states:**
  - IDLE: waiting for a request.
  - PLAY: emitting the note.
  - GAP: forced silence at the end of a note.
- **Leaving IDLE.** A valid `startReq` loads the melody, sets note index 0, clears the beat counter, and moves to PLAY.
- **PLAY and GAP.**
  - A note of length L occupies exactly L·BEAT_CYCLES cycles in total.
  - PLAY lasts for the first L·BEAT_CYCLES − GAP_CYCLES of those cycles, and GAP lasts for the remaining GAP_CYCLES.
  - If GAP_CYCLES=0, the GAP state is skipped.
  - A table entry with note F plays as silence for its full length.
- **End of note.** The index advances.
  - If the next entry has length 0, or the index reaches MAX_NOTES, the melody ends.
  - At melody end with `loopEn`=1, playback restarts at index 0 with no idle cycle and no `melodyDone`.
  - At melody end with `loopEn`=0, the FSM goes to IDLE and pulses `melodyDone`.
- **Preemption.** A valid `startReq` while busy restarts playback only if the new priority is ≥ the current priority; an equal-priority request restarts from index 0. A lower-priority request is dropped. A preempted melody produces no `melodyDone`.
- **Stop.** `stopReq` sends the FSM to IDLE on the next cycle. No `melodyDone` is produced.
- **Simultaneous events:**
  - `stopReq` together with `startReq`: stop wins.
  - An accepted `startReq` in the same cycle as the melody ending: start wins, and `melodyDone` is suppressed.
  - `reset` overrides everything.

## Timing
- **Reset values:**
  - `tone`=4'hF, `silenceOutN`=0, `busy`=0, `melodyDone`=0, `curMelody`=0.
  - FSM in IDLE, all counters 0.
- **Registered outputs.**
  - All outputs are registered.
  - `tone`, `busy` and `curMelody` change on the edge after the request is sampled, giving a latency of 1 cycle.
- **Example timeline.** Take a request sampled at edge k:
  - The first note appears at k+1.
  - The melody's last cycle is k+T, where T = Σlen·BEAT_CYCLES.
  - At k+T+1, `busy` falls, `tone` becomes F, `curMelody` becomes 0, and `melodyDone` is 1 for exactly one cycle.
- **Stop timing.** For `stopReq` sampled at edge s, the outputs return to reset values at s+1.
- **Counter widths.**
  - The beat counter is wide enough for 15·BEAT_CYCLES − 1.
  - The counter is compared, never wrapped.
  - The index counter saturates at MAX_NOTES and then terminates the melody.

## Test plan
(All scenarios use BEAT_CYCLES=4, GAP_CYCLES=1.)
- **Win, natural end.** `startReq` with ID 1 at edge 0 ->
  - `tone` is 0 for cycles 1–3 and F at cycle 4.
  - `tone` is 4 for 5–7 and 7 for 9–11.
  - `tone` is C for 13–27 and F at 28.
  - `melodyDone`=1 only at cycle 29, and `busy` is 0 from cycle 29.
- **Looped claw.** ID 3 with `loopEn`=1 ->
  - The pattern 2,3,2,3 repeats with period 16 cycles.
  - `busy` stays 1 and `melodyDone` never pulses.
  - Dropping `loopEn` lets the current pass finish, then `melodyDone` pulses.
- **Preemption rules.**
  - ID 3 playing, `startReq` ID 4 at cycle 6 -> `tone`=B and `curMelody`=4 at cycle 7.
  - ID 4 playing, request for ID 3 -> ignored, `curMelody` stays 4.
- **Stop conflicts.** `stopReq` and `startReq` with ID 1 in the same cycle mid-melody -> next cycle `busy`=0, `tone`=F, no `melodyDone`.
- **Invalid IDs.** `startReq` with ID 0 or ID 9 while idle -> all outputs stay at reset values.
- **Reset mid-note.** `reset` asserted during a note of ID 2 -> next cycle the reset values are restored, and a new start behaves as the first scenario.
